// File: rtl/esas_sqrt_arbiter.sv
// esas_sqrt_arbiter
//   Shares one combinational 32-bit -> 16-bit integer square-root datapath
//   among NUM_REQ requesters. A round-robin arbiter picks one valid operand,
//   registers it, holds it for SETTLE_CYC cycles (so the datapath can be
//   timed as a multicycle path), captures the root and returns it on a
//   single tagged response channel.
//
//   Optional build macro: ESAS_ZERO_BYPASS_EN
//     defined   : a granted operand of 0 skips CALC and is answered with 0
//                 directly from IDLE.
//     undefined : 0 goes through the datapath like any other operand and
//                 comes back as 1 (the datapath's answer for 0).
//
// Ports
//   clk         single clock
//   rst         asynchronous active-high reset
//   req_valid   [NUM_REQ]     per-requester operand valid
//   req_ready   [NUM_REQ]     per-requester accept, one-hot or zero
//   req_data    [32*NUM_REQ]  operands, requester i at [32*i+31:32*i]
//   resp_valid  result valid
//   resp_ready  consumer accepts the result
//   resp_id     [ID_W]        requester index the result belongs to
//   resp_sqrt   [16]          integer square root
//   busy        high whenever the FSM is not IDLE
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A producer holding valid keeps its payload stable until the
// transfer; ready never depends on the payload. Requesters may drop valid
// while not granted. resp_valid/resp_id/resp_sqrt are held until accepted.

module esas_sqrt_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [15:0]             resp_sqrt,
  output logic                    busy
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       op_q;
  logic [CNT_W-1:0]  cnt;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic [31:0]       grant_data;
  logic [15:0]       dp_root;

  // Restoring digit-by-digit square root, fully unrolled. The datapath
  // reports 1 for an input of 0 (its root register never reads as zero);
  // every non-zero input yields floor(sqrt(x)).
  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [33:0] rem;
    logic [33:0] trial;
    logic [15:0] q;
    rem = '0;
    q   = '0;
    for (int i = 15; i >= 0; i--) begin
      rem   = {rem[31:0], x[2*i+1 -: 2]};
      trial = {16'b0, q, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        q   = {q[14:0], 1'b1};
      end else begin
        q   = {q[14:0], 1'b0};
      end
    end
    if (q == 16'd0) begin
      q = 16'd1;
    end
    return q;
  endfunction

  assign dp_root = isqrt32(op_q);
  assign busy    = (state != IDLE);

  // Round-robin scan starting just after the last winner, so the most
  // recent winner is always considered last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    grant_data = req_data[{grant_idx, 5'b0} +: 32];
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      op_q       <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sqrt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_q   <= grant_data;
            id_q   <= grant_idx;
            rr_ptr <= grant_idx;
            cnt    <= CNT_W'(SETTLE_CYC - 1);
`ifdef ESAS_ZERO_BYPASS_EN
            if (grant_data == 32'd0) begin
              resp_sqrt  <= 16'd0;
              resp_id    <= grant_idx;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state      <= CALC;
            end
`else
            state  <= CALC;
`endif
          end
        end
        CALC: begin
          if (cnt == '0) begin
            resp_sqrt  <= dp_root;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/esas_sqrt_arbiter.md
Name: esas_sqrt_arbiter

Overview:
- Shares one ESAS_integer square-root datapath (32-bit operand in, 16-bit root out, purely combinational) among NUM_REQ requesters.
- Arbitrates round-robin and registers the operand into the datapath.
- Holds the operand stable for SETTLE_CYC cycles so the datapath can be constrained as a multicycle path.
- Captures the root and returns it on a single tagged response channel with valid/ready flow control.

Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- ID_W, 2: width of resp_id; NUM_REQ <= 2**ID_W.
- SETTLE_CYC, 2: cycles the operand is held before the result is captured; >= 1.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  in  32*NUM_REQ  operands; requester i uses bits [32*i+31:32*i].
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester the result belongs to.
- resp_sqrt  out  16  integer square root.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - rst asserted: state=IDLE, resp_valid=0, resp_id=0, resp_sqrt=0, busy=0, rr_ptr=NUM_REQ-1.
  - req_ready is forced to 0 while rst is high.
  - Reset mid-operation discards the in-flight request with no response.
- State IDLE:
  - Winner g = first i with req_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally; all other bits 0. No valid means req_ready=0.
  - On the handshake edge: op_q<=req_data[g], id_q<=g, rr_ptr<=g, cnt<=SETTLE_CYC-1, go to CALC.
- State CALC:
  - op_q drives the datapath; op_q is stable for the whole state.
  - Each cycle with cnt!=0: cnt<=cnt-1.
  - At cnt==0: resp_sqrt<=datapath output, resp_id<=id_q, resp_valid<=1, go to RESP.
  - CALC therefore lasts exactly SETTLE_CYC cycles.
- State RESP:
  - resp_valid, resp_id and resp_sqrt stay stable until resp_ready=1.
  - On the handshake edge: resp_valid<=0, go to IDLE. resp_sqrt and resp_id keep their last value.
  - req_ready=0 in CALC and RESP; no new request is taken until IDLE.
- Timing:
  - Latency: request accepted at edge t gives resp_valid=1 after edge t+SETTLE_CYC.
  - Best-case throughput: one result every SETTLE_CYC+2 cycles.
- Fairness:
  - A requester that just won has the lowest priority next round.
  - With all requesters valid continuously, grants go 0,1,2,...,NUM_REQ-1,0,...
- Flow control:
  - req_valid dropping while not granted is legal and ignored.
  - req_data of a non-granted requester is never sampled.
  - resp_ready asserted outside RESP has no effect.

Optional Feature:
- Macro: ESAS_ZERO_BYPASS_EN.
- Defined: a granted operand of 0 goes from IDLE directly to RESP with resp_sqrt=0, skipping CALC. Response arrives one cycle after acceptance. This corrects the datapath result of 1 for input 0.
- Undefined: zero is handled like any operand; resp_sqrt=1 for input 0 after SETTLE_CYC.

Test Plan:
- Single request: rst pulse, req_valid=4'b0001, req_data[31:0]=65536, resp_ready=1 -> resp_valid rises 2 cycles after acceptance, resp_sqrt=256, resp_id=0, busy high for 3 cycles.
- Round-robin: all 4 valid with operands 4,16,65536,4, resp_ready=1 -> grant order 0,1,2,3; resp_sqrt 2,4,256,2; resp_id 0,1,2,3; no requester granted twice before all are served.
- Backpressure: resp_ready=0 for 10 cycles in RESP with operand 16 -> resp_valid, resp_id and resp_sqrt=4 held stable; req_ready=0 throughout; completes on the first resp_ready=1.
- Reset mid-CALC: assert rst one cycle after accepting 65536 -> resp_valid=0, busy=0, no response emitted; next request from requester 0 is granted first.
- Zero operand: req_data=0 -> resp_sqrt=0 one cycle after accept with ESAS_ZERO_BYPASS_EN; resp_sqrt=1 after SETTLE_CYC without it.
- SETTLE_CYC=4 build: operand 16 -> resp_valid rises 4 cycles after acceptance, resp_sqrt=4.
